// File: rtl/wb_tx_fetch.sv
// Read-only Wishbone fetcher: reads word_cnt words from base_adr into an output FWFT FIFO.
// A bus cycle is issued only when the FIFO has room; optional RTY retry via WB_TX_FETCH_RETRY_EN.
module wb_tx_fetch #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_RETRY  = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [11:0] word_cnt,
  output logic        busy,
  output logic        done,
  output logic        fetch_err,
  output logic [31:0] m_wb_adr_o,
  output logic [3:0]  m_wb_sel_o,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic [31:0] m_wb_dat_o,
  input  logic [31:0] m_wb_dat_i,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_err_i,
  input  logic        m_wb_rty_i,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, BUS, GAP} state_e;
  typedef logic [AW:0] ptr_t;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [11:0]   rem_q, rem_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  ptr_t          wr_ptr_q, rd_ptr_q, count;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic          push, pop, abort, fifo_full;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count     = wr_ptr_q - rd_ptr_q;
  assign fifo_full = count[AW];
  assign out_valid = (count != '0);
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop       = out_valid & out_ready;

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign fetch_err  = err_q;
  assign m_wb_adr_o = addr_q;
  assign m_wb_sel_o = 4'hF;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_dat_o = '0;
  assign m_wb_cyc_o = (state_q == BUS);
  assign m_wb_stb_o = (state_q == BUS);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_cnt == 12'd0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_adr;
            rem_d   = word_cnt;
            retry_d = '0;
            err_d   = 1'b0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (!fifo_full) state_d = BUS;
      end
      BUS: begin
        if (m_wb_err_i) begin
          abort = 1'b1;
        end else if (m_wb_rty_i) begin
`ifdef WB_TX_FETCH_RETRY_EN
          if (retry_q + RW'(1) == RW'(MAX_RETRY)) begin
            abort = 1'b1;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = GAP;
          end
`else
          abort = 1'b1;
`endif
        end else if (m_wb_ack_i) begin
          push    = 1'b1;
          addr_d  = addr_q + 32'd4;
          rem_d   = rem_q - 12'd1;
          retry_d = '0;
          if (rem_q == 12'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      err_d   = 1'b1;
      done_d  = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      retry_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= m_wb_dat_i;
  end

endmodule
